// File: rtl/pipe_ctrl_pkg.sv
// Shared codes for the pipeline stall/flush controller: stall vector
// encodings, multi-cycle sequencer state codes and the stall priority encoder.
package pipe_ctrl_pkg;

  // Single-bit stall sense for each pipeline register.
  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  // Stall vectors. bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB,
  // bit5 reserved and never set. A request from a stage also holds every
  // stage in front of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  // Multi-cycle sequencer states.
  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

  // Highest stage wins: MEM over EX over ID.
  function automatic logic [5:0] stall_encode(input logic mem_req,
                                              input logic ex_req,
                                              input logic id_req);
    logic [5:0] vec;
    vec = STALL_NONE;
    if (mem_req == STALL_ENABLE) begin
      vec = STALL_MEM;
    end else if (ex_req == STALL_ENABLE) begin
      vec = STALL_EX;
    end else if (id_req == STALL_ENABLE) begin
      vec = STALL_ID;
    end
    return vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mc_seq.sv
// Multi-cycle EX operation sequencer: IDLE -> BUSY (counting down the extra
// cycles the op needs) -> DONE (result presented until EX/MEM captures it).
//
// Result handshake: `done` acts as valid and `capture` (EX/MEM not stalled
// this cycle) acts as ready; the result is consumed in the cycle where both
// are high, and DONE is left at the following edge. `done` never drops
// before that cycle except on flush or reset.
module mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MC_LEN_W-1:0] len,
  input  logic                flush,
  input  logic                capture,
  output mc_state_e           state,
  output logic                busy,
  output logic                done,
  output logic                ex_req
);

  localparam logic [MC_LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [MC_LEN_W-1:0] LEN_ONE  = {{(MC_LEN_W-1){1'b0}}, 1'b1};

  mc_state_e           state_next;
  logic [MC_LEN_W-1:0] cnt;
  logic [MC_LEN_W-1:0] cnt_next;

  // State and down-counter registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt   <= LEN_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter update; flush overrides every transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = MC_IDLE;
      cnt_next   = LEN_ZERO;
    end else begin
      case (state)
        MC_IDLE: begin
          if (start) begin
            // A zero-length op needs no extra cycles: result is ready next.
            if (len == LEN_ZERO) begin
              state_next = MC_DONE;
              cnt_next   = LEN_ZERO;
            end else begin
              state_next = MC_BUSY;
              cnt_next   = len;
            end
          end
        end
        MC_BUSY: begin
          // Only entered with cnt >= 1, so this never underflows.
          cnt_next = cnt - LEN_ONE;
          if (cnt == LEN_ONE) begin
            state_next = MC_DONE;
          end
        end
        MC_DONE: begin
          if (capture) begin
            state_next = MC_IDLE;
          end
        end
        default: begin
          state_next = MC_IDLE;
          cnt_next   = LEN_ZERO;
        end
      endcase
    end
  end

  // Status decode. The start cycle itself already holds the front of the
  // pipe so the op's operands stay in ID/EX.
  assign busy   = (state != MC_IDLE);
  assign done   = (state == MC_DONE);
  assign ex_req = ((state == MC_IDLE) && start) || (state == MC_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: merges stage
// stall requests into one priority-encoded stall vector, sequences multi-cycle
// EX ops, generates the exception flush and counts front-end stall cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_id,
  input  logic                stallreq_from_ex,
  input  logic                stallreq_from_mem,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                flush_req,
  output logic [5:0]          stall,
  output logic                flush,
  output logic                ex_mc_done,
  output logic                mc_busy,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  mc_state_e mc_state;
  logic      mc_busy_int;
  logic      mc_done_int;
  logic      mc_ex_req;
  logic      ex_side_req;
  logic      ex_mem_capture;

  // EX/MEM captures whenever it is not held; this is what retires a DONE op.
  assign ex_mem_capture = (stall[3] == STALL_DISABLE);

  mc_seq #(
    .MC_LEN_W (MC_LEN_W)
  ) u_mc_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (ex_mc_start),
    .len     (ex_mc_len),
    .flush   (flush_req),
    .capture (ex_mem_capture),
    .state   (mc_state),
    .busy    (mc_busy_int),
    .done    (mc_done_int),
    .ex_req  (mc_ex_req)
  );

  assign ex_side_req = stallreq_from_ex | mc_ex_req;

  // Stall vector: priority encode, but a flush cycle never stalls so the
  // cleared registers actually load their bubbles.
  always_comb begin
    stall = STALL_NONE;
    if (!flush_req) begin
      stall = stall_encode(stallreq_from_mem, ex_side_req, stallreq_from_id);
    end
  end

  assign flush      = flush_req;
  assign ex_mc_done = mc_done_int;
  // mc_state is the sequencer's state; busy mirrors "not IDLE" from it.
  assign mc_busy    = mc_busy_int && (mc_state != MC_IDLE);

  // Free-running count of cycles with the PC held; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= CNT_ZERO;
    end else if (stall[0] == STALL_ENABLE) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule
